apb_mem_slave: RTL and testbench

APB completer that sits directly downstream of the `apb` master. It terminates `pselx`/`penable`/`pwrite`/`paddr`/`pwdata` in a word-addressed register memory and returns `pready`, `pslverr` and `prdata`. Wait states are inserted per transfer, and out-of-range, misaligned or read-only-violating accesses are flagged with `pslverr`. It is the default peripheral behind the bridge and the reference target for master verification.

---
 rtl/apb_mem_slave.sv | 169 ++++++++++++++++
 tb/tb_apb_mem_slave.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/apb_mem_slave.sv
// APB completer backed by a word-addressed register memory.
// It inserts a fixed number of wait states per transfer and flags misaligned,
// out-of-range and read-only-violating accesses with pslverr.
module apb_mem_slave #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned MEM_DEPTH   = 64,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned RO_WORDS    = 4,
    parameter logic [31:0] ID_VALUE    = 32'hA5B0_0000
) (
    input  logic                  pclk,
    input  logic                  preset,
    input  logic                  pselx,
    input  logic                  penable,
    input  logic                  pwrite,
    input  logic [ADDR_WIDTH-1:0] paddr,
    input  logic [DATA_WIDTH-1:0] pwdata,
    output logic                  pready,
    output logic                  pslverr,
    output logic [DATA_WIDTH-1:0] prdata
);

    localparam int unsigned IDX_W  = ADDR_WIDTH - 2;
    localparam int unsigned CMP_W  = (IDX_W > 32) ? IDX_W : 32;
    localparam int unsigned MEM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic                    write_q, write_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    pready_q, pready_d;
    logic                    pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
    logic [DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

    logic [ADDR_WIDTH-1:0]   chk_addr_c;
    logic                    chk_wr_c;
    logic [IDX_W-1:0]        chk_idx_c;
    logic [MEM_AW-1:0]       mem_idx_c;
    logic                    ro_c;
    logic                    err_c;
    logic [DATA_WIDTH-1:0]   rd_c;
    logic                    mem_we_c;

    // Response decode: in IDLE the live bus is decoded so a zero-wait transfer
    // can answer on its capture edge; afterwards only captured values are used.
    always_comb begin
        chk_addr_c = (state_q == ST_IDLE) ? paddr  : addr_q;
        chk_wr_c   = (state_q == ST_IDLE) ? pwrite : write_q;
        chk_idx_c  = chk_addr_c[ADDR_WIDTH-1:2];
        mem_idx_c  = MEM_AW'(chk_idx_c);
        ro_c       = CMP_W'(chk_idx_c) < CMP_W'(RO_WORDS);
        err_c      = (chk_addr_c[1:0] != 2'b00)
                   || (CMP_W'(chk_idx_c) >= CMP_W'(MEM_DEPTH))
                   || (chk_wr_c && ro_c);
        if (err_c || chk_wr_c) begin
            rd_c = '0;
        end else if (ro_c) begin
            rd_c = DATA_WIDTH'(ID_VALUE) + DATA_WIDTH'(chk_idx_c);
        end else begin
            rd_c = mem_q[mem_idx_c];
        end
    end

    // Next-state logic: capture, wait countdown, response hold, completion/abort.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        pready_d  = pready_q;
        pslverr_d = pslverr_q;
        prdata_d  = prdata_q;
        mem_we_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pselx && !penable) begin
                    addr_d  = paddr;
                    write_d = pwrite;
                    wdata_d = pwdata;
                    if (WAIT_CYCLES == 0) begin
                        cnt_d     = '0;
                        pready_d  = 1'b1;
                        pslverr_d = err_c;
                        prdata_d  = rd_c;
                        state_d   = ST_RESP;
                    end else begin
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!pselx) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q <= CNT_W'(1)) begin
                        pready_d  = 1'b1;
                        pslverr_d = err_c;
                        prdata_d  = rd_c;
                        state_d   = ST_RESP;
                    end
                end
            end
            ST_RESP: begin
                if (!pselx || penable) begin
                    // Completion commits a clean write; an abort drops it.
                    mem_we_c  = pselx && write_q && !pslverr_q;
                    pready_d  = 1'b0;
                    pslverr_d = 1'b0;
                    prdata_d  = '0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                prdata_d  = '0;
                state_d   = ST_IDLE;
            end
        endcase
    end

    // State, output and memory registers with synchronous reset.
    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
            for (int i = 0; i < int'(MEM_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            write_q   <= write_d;
            wdata_q   <= wdata_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
            if (mem_we_c) begin
                mem_q[mem_idx_c] <= wdata_q;
            end
        end
    end

    assign pready  = pready_q;
    assign pslverr = pslverr_q;
    assign prdata  = prdata_q;

endmodule

// File: tb/tb_apb_mem_slave.sv
// Scoreboard bench for apb_mem_slave: three instances with WAIT_CYCLES 1, 0 and 3
// share the bus; only the instance selected by 'cur' sees pselx.
module tb_apb_mem_slave;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic          pclk = 1'b0;
    logic          preset;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    int            cur;

    logic [2:0]    pready_v;
    logic [2:0]    pslverr_v;
    logic [DW-1:0] prdata_v [3];

    logic          pready_m;
    logic          pslverr_m;
    logic [DW-1:0] prdata_m;

    always #5 pclk = ~pclk;

    apb_mem_slave #(.WAIT_CYCLES(1)) u_wc1 (
        .pclk(pclk), .preset(preset), .pselx(psel && (cur == 0)), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready_v[0]), .pslverr(pslverr_v[0]), .prdata(prdata_v[0])
    );
    apb_mem_slave #(.WAIT_CYCLES(0)) u_wc0 (
        .pclk(pclk), .preset(preset), .pselx(psel && (cur == 1)), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready_v[1]), .pslverr(pslverr_v[1]), .prdata(prdata_v[1])
    );
    apb_mem_slave #(.WAIT_CYCLES(3)) u_wc3 (
        .pclk(pclk), .preset(preset), .pselx(psel && (cur == 2)), .penable(penable),
        .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pready(pready_v[2]), .pslverr(pslverr_v[2]), .prdata(prdata_v[2])
    );

    assign pready_m  = pready_v[cur];
    assign pslverr_m = pslverr_v[cur];
    assign prdata_m  = prdata_v[cur];

    typedef struct {
        logic        rd;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   setup_cyc = 0;
    logic prev_rdy  = 1'b0;

    function automatic int wc_of(input int c);
        return (c == 0) ? 1 : (c == 1) ? 0 : 3;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Monitor: timestamps captured setups and scores every new pready pulse.
    initial begin
        exp_t e;
        forever begin
            @(posedge pclk);
            cyc++;
            if (!preset && psel && !penable) setup_cyc = cyc;
            #1;
            if (pready_m && !prev_rdy) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_pready", 1, 0);
                end else begin
                    e = sb_q.pop_front();
                    check($sformatf("latency_dut%0d", cur), cyc - setup_cyc, e.lat);
                    check($sformatf("pslverr_dut%0d", cur), pslverr_m, e.err);
                    if (e.rd) check($sformatf("prdata_dut%0d", cur), prdata_m, e.rdata);
                end
            end
            prev_rdy = pready_m;
        end
    end

    function automatic void push_exp(input logic wr, input logic [31:0] rd, input logic err);
        exp_t e;
        e.rd = !wr;
        e.rdata = rd;
        e.err = err;
        e.lat = wc_of(cur);
        sb_q.push_back(e);
    endfunction

    // Setup phase then access phase; returns once pready is seen (bounded).
    task automatic start_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              output int n);
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d;
        @(posedge pclk); #1;
        penable = 1'b1;
        // Bus contents after capture must be ignored by the completer.
        paddr = 32'hFFFF_FFF3; pwdata = ~d; pwrite = ~wr;
        n = 1;
        while (pready_m !== 1'b1 && n < 40) begin
            @(posedge pclk); #1;
            n++;
        end
        if (n >= 40) check("pready_timeout", 0, 1);
    endtask

    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic exp_err);
        int n;
        push_exp(wr, exp_rd, exp_err);
        start_xfer(wr, a, d, n);
        @(posedge pclk); #1;
        n++;
        check($sformatf("xfer_cycles_dut%0d", cur), n, wc_of(cur) + 2);
        check("pready_cleared", pready_m, 0);
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; cur = 0;
        repeat (3) @(posedge pclk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset_pready%0d", i), pready_v[i], 0);
            check($sformatf("reset_pslverr%0d", i), pslverr_v[i], 0);
            check($sformatf("reset_prdata%0d", i), prdata_v[i], 0);
        end
        preset = 1'b0;
        @(posedge pclk); #1;

        // WAIT_CYCLES=1: basic write/read, ID words, read-only and error accesses.
        cur = 0;
        xfer(1, 32'h10, 32'hDEADBEEF, 0, 0);
        xfer(0, 32'h10, 0, 32'hDEADBEEF, 0);
        xfer(0, 32'h08, 0, 32'hA5B0_0002, 0);
        xfer(1, 32'h08, 32'h1234, 0, 1);
        xfer(0, 32'h08, 0, 32'hA5B0_0002, 0);
        xfer(0, 32'h00, 0, 32'hA5B0_0000, 0);
        xfer(0, 32'h0C, 0, 32'hA5B0_0003, 0);
        xfer(1, 32'h102, 32'h5555, 0, 1);
        xfer(0, 32'h102, 0, 0, 1);
        xfer(1, 32'h100, 32'h6666, 0, 1);
        xfer(0, 32'h100, 0, 0, 1);
        xfer(1, 32'h12, 32'h7777, 0, 1);
        xfer(0, 32'h11, 0, 0, 1);
        xfer(0, 32'h10, 0, 32'hDEADBEEF, 0);
        xfer(0, 32'hFC, 0, 0, 0);
        xfer(1, 32'hFC, 32'hCAFE_F00D, 0, 0);
        xfer(0, 32'hFC, 0, 32'hCAFE_F00D, 0);
        xfer(0, 32'h00, 0, 32'hA5B0_0000, 0);

        // WAIT_CYCLES=0 and 3: back-to-back writes then readbacks.
        for (int k = 1; k <= 2; k++) begin
            cur = k;
            xfer(1, 32'h20, 32'h1111_0020 + k, 0, 0);
            xfer(1, 32'h24, 32'h2222_0024 + k, 0, 0);
            xfer(0, 32'h20, 0, 32'h1111_0020 + k, 0);
            xfer(0, 32'h24, 0, 32'h2222_0024 + k, 0);
            @(posedge pclk); #1;
        end

        // Protocol violation in IDLE is ignored.
        cur = 1;
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 32'h20; pwdata = 32'h0BAD;
        repeat (3) begin
            @(posedge pclk); #1;
            check("violation_no_pready", pready_m, 0);
        end
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        xfer(0, 32'h20, 0, 32'h1111_0021, 0);

        // Abort during WAIT on WAIT_CYCLES=3: no response, write discarded.
        cur = 2;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h30; pwdata = 32'hDEAD0030;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        repeat (6) begin
            @(posedge pclk); #1;
            check("abort_no_pready", pready_m, 0);
        end
        xfer(0, 32'h30, 0, 0, 0);

        // Reset while in RESP on WAIT_CYCLES=1.
        cur = 0;
        push_exp(1, 0, 0);
        start_xfer(1, 32'h34, 32'h5A5A_5A5A, n);
        preset = 1'b1;
        @(posedge pclk); #1;
        check("rst_resp_pready", pready_v[0], 0);
        check("rst_resp_pslverr", pslverr_v[0], 0);
        check("rst_resp_prdata", prdata_v[0], 0);
        preset = 1'b0; psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        xfer(0, 32'h34, 0, 0, 0);
        xfer(0, 32'h10, 0, 0, 0);
        xfer(0, 32'h04, 0, 32'hA5B0_0001, 0);

        repeat (3) @(posedge pclk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
